leds_pwm: RTL and testbench

//  Memory-mapped LED output controller on the CPU MMIO bus; next generation of the 16-bit LED port.

---
 rtl/leds_pkg.sv | 13 +
 rtl/leds_pwm_gen.sv | 44 ++++
 rtl/leds_pwm.sv | 95 +++++++++
 tb/tb_leds_pwm.sv | 185 ++++++++++++++++++
 4 files changed

// File: rtl/leds_pkg.sv
// Shared register offsets and address helpers for the LED PWM controller.
package leds_pkg;

  localparam logic [3:0] LED_REG_DATA  = 4'h0;
  localparam logic [3:0] LED_REG_BLINK = 4'h4;
  localparam logic [3:0] LED_REG_DUTY  = 4'h8;
  localparam logic [3:0] LED_REG_TOGL  = 4'hC;

  function automatic logic addr_aligned(input logic [3:0] addr);
    return (addr[1:0] == 2'b00);
  endfunction

endpackage

// File: rtl/leds_pwm_gen.sv
// Blink prescaler/phase and free-running PWM counter shared by all LEDs.
module leds_pwm_gen #(
  parameter int unsigned BLINK_DIV = 2500000,
  parameter int unsigned PWM_W     = 8
) (
  input  logic             led_clk,
  input  logic             ledrst_n,
  input  logic [PWM_W-1:0] duty,
  output logic             phase,
  output logic             pwm_on
);

  localparam int unsigned PRE_W = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(BLINK_DIV - 1);

  logic [PRE_W-1:0] prescaler_q, prescaler_d;
  logic             phase_q, phase_d;
  logic [PWM_W-1:0] pwm_cnt_q, pwm_cnt_d;
  logic             pre_tick;

  always_comb begin
    pre_tick    = (prescaler_q == PRE_LAST);
    prescaler_d = pre_tick ? '0 : prescaler_q + PRE_W'(1);
    phase_d     = phase_q ^ pre_tick;
    pwm_cnt_d   = pwm_cnt_q + PWM_W'(1);
  end

  always_ff @(posedge led_clk or negedge ledrst_n) begin
    if (!ledrst_n) begin
      prescaler_q <= '0;
      phase_q     <= 1'b0;
      pwm_cnt_q   <= '0;
    end else begin
      prescaler_q <= prescaler_d;
      phase_q     <= phase_d;
      pwm_cnt_q   <= pwm_cnt_d;
    end
  end

  // Full-scale duty bypasses the compare so the LED never blanks at pwm_cnt == max.
  assign phase  = phase_q;
  assign pwm_on = (duty == '1) | (pwm_cnt_q < duty);

endmodule

// File: rtl/leds_pwm.sv
// MMIO LED port: DATA/BLINK/DUTY/TOGL registers, registered readback and masked LED drive.
module leds_pwm
  import leds_pkg::*;
#(
  parameter int unsigned LED_W     = 24,
  parameter int unsigned BLINK_DIV = 2500000,
  parameter int unsigned PWM_W     = 8
) (
  input  logic             led_clk,
  input  logic             ledrst_n,
  input  logic             ledcs,
  input  logic             ledwrite,
  input  logic             ledread,
  input  logic [3:0]       ledaddr,
  input  logic [31:0]      ledwdata,
  output logic [31:0]      ledrdata,
  output logic [LED_W-1:0] ledout
);

  logic [LED_W-1:0] data_q, data_d;
  logic [LED_W-1:0] blink_q, blink_d;
  logic [PWM_W-1:0] duty_q, duty_d;
  logic [31:0]      ledrdata_q, ledrdata_d;
  logic [LED_W-1:0] ledout_q, ledout_d;
  logic [31:0]      rd_word;
  logic             wr_en, rd_en, aligned;
  logic             phase, pwm_on;
  logic             unused_wdata;

  // Upper write-data bits are architecturally ignored for narrower registers.
  assign unused_wdata = ^ledwdata;

  leds_pwm_gen #(
    .BLINK_DIV (BLINK_DIV),
    .PWM_W     (PWM_W)
  ) u_gen (
    .led_clk  (led_clk),
    .ledrst_n (ledrst_n),
    .duty     (duty_q),
    .phase    (phase),
    .pwm_on   (pwm_on)
  );

  always_comb begin
    wr_en   = ledcs & ledwrite;
    rd_en   = ledcs & ledread;
    aligned = addr_aligned(ledaddr);
    data_d  = data_q;
    blink_d = blink_q;
    duty_d  = duty_q;
    if (wr_en && aligned) begin
      case (ledaddr)
        LED_REG_DATA:  data_d  = ledwdata[LED_W-1:0];
        LED_REG_BLINK: blink_d = ledwdata[LED_W-1:0];
        LED_REG_DUTY:  duty_d  = ledwdata[PWM_W-1:0];
        LED_REG_TOGL:  data_d  = data_q ^ ledwdata[LED_W-1:0];
        default:       ;
      endcase
    end

    // Readback uses pre-write register values so a same-cycle write returns the old contents.
    rd_word = '0;
    if (aligned) begin
      case (ledaddr)
        LED_REG_DATA:  rd_word[LED_W-1:0] = data_q;
        LED_REG_BLINK: rd_word[LED_W-1:0] = blink_q;
        LED_REG_DUTY:  rd_word[PWM_W-1:0] = duty_q;
        default:       ;
      endcase
    end
    ledrdata_d = rd_en ? rd_word : ledrdata_q;

    ledout_d = data_q & ~(blink_q & {LED_W{phase}}) & {LED_W{pwm_on}};
  end

  always_ff @(posedge led_clk or negedge ledrst_n) begin
    if (!ledrst_n) begin
      data_q     <= '0;
      blink_q    <= '0;
      duty_q     <= '1;
      ledrdata_q <= '0;
      ledout_q   <= '0;
    end else begin
      data_q     <= data_d;
      blink_q    <= blink_d;
      duty_q     <= duty_d;
      ledrdata_q <= ledrdata_d;
      ledout_q   <= ledout_d;
    end
  end

  assign ledrdata = ledrdata_q;
  assign ledout   = ledout_q;

endmodule

// File: tb/tb_leds_pwm.sv
// Directed bench for leds_pwm with LED_W=24, BLINK_DIV=4, PWM_W=8.
module tb_leds_pwm;

  localparam int LED_W = 24;

  logic             led_clk = 1'b0;
  logic             ledrst_n;
  logic             ledcs, ledwrite, ledread;
  logic [3:0]       ledaddr;
  logic [31:0]      ledwdata;
  logic [31:0]      ledrdata;
  logic [LED_W-1:0] ledout;

  int n_checks = 0;
  int n_fail   = 0;

  leds_pwm #(.LED_W(LED_W), .BLINK_DIV(4), .PWM_W(8)) dut (
    .led_clk  (led_clk),
    .ledrst_n (ledrst_n),
    .ledcs    (ledcs),
    .ledwrite (ledwrite),
    .ledread  (ledread),
    .ledaddr  (ledaddr),
    .ledwdata (ledwdata),
    .ledrdata (ledrdata),
    .ledout   (ledout)
  );

  always #5 led_clk = ~led_clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic bus_wr(input logic [3:0] addr, input logic [31:0] data);
    @(negedge led_clk);
    ledcs = 1'b1; ledwrite = 1'b1; ledaddr = addr; ledwdata = data;
    @(negedge led_clk);
    ledcs = 1'b0; ledwrite = 1'b0;
  endtask

  task automatic bus_rd(input logic [3:0] addr, output logic [31:0] data);
    @(negedge led_clk);
    ledcs = 1'b1; ledread = 1'b1; ledaddr = addr;
    @(negedge led_clk);
    ledcs = 1'b0; ledread = 1'b0;
    data = ledrdata;
  endtask

  initial begin
    logic [31:0] rv;
    int cnt, trans, last_edge, b1_bad;
    logic prev;

    ledrst_n = 1'b0; ledcs = 1'b0; ledwrite = 1'b0; ledread = 1'b0;
    ledaddr = '0; ledwdata = '0;
    repeat (3) @(negedge led_clk);
    ledrst_n = 1'b1;

    // 1: reset state and async reset mid-run
    @(negedge led_clk);
    check_eq("rst_ledout", 32'(ledout), 32'h0);
    check_eq("rst_ledrdata", ledrdata, 32'h0);
    repeat (5) @(negedge led_clk);
    check_eq("rst_idle_ledout", 32'(ledout), 32'h0);
    bus_rd(LED_REG_DUTY_ADDR(), rv);
    check_eq("rst_duty", rv, 32'hFF);
    bus_wr(4'h0, 32'h0000_0F0F);
    @(negedge led_clk);
    check_eq("pre_rst_ledout", 32'(ledout), 32'h0F0F);
    #2 ledrst_n = 1'b0;
    #1 check_eq("async_rst_ledout", 32'(ledout), 32'h0);
    @(negedge led_clk);
    ledrst_n = 1'b1;
    repeat (3) @(negedge led_clk);
    check_eq("post_rst_ledout", 32'(ledout), 32'h0);
    bus_rd(4'h0, rv);
    check_eq("post_rst_data", rv, 32'h0);

    // 2: DATA write and one-cycle output latency
    bus_wr(4'h0, 32'h00A5_A5A5);
    check_eq("data_lat_old", 32'(ledout), 32'h0);
    @(negedge led_clk);
    check_eq("data_lat_new", 32'(ledout), 32'hA5A5A5);
    bus_rd(4'h0, rv);
    check_eq("data_rd", rv, 32'h00A5_A5A5);
    @(negedge led_clk);
    ledcs = 1'b0; ledwrite = 1'b1; ledaddr = 4'h0; ledwdata = 32'h0000_1234;
    @(negedge led_clk);
    ledwrite = 1'b0;
    bus_rd(4'h0, rv);
    check_eq("nocs_wr", rv, 32'h00A5_A5A5);

    // 3: toggle and width truncation
    bus_wr(4'hC, 32'h0000_FFFF);
    bus_rd(4'h0, rv);
    check_eq("togl_data", rv, 32'h00A5_5A5A);
    check_eq("togl_ledout", 32'(ledout), 32'hA55A5A);
    bus_rd(4'hC, rv);
    check_eq("togl_rd", rv, 32'h0);
    bus_wr(4'h0, 32'hFF00_0000);
    bus_rd(4'h0, rv);
    check_eq("data_trunc", rv, 32'h0);
    check_eq("data_trunc_out", 32'(ledout), 32'h0);

    // 4: blink with BLINK_DIV=4
    bus_wr(4'h4, 32'h0000_0001);
    bus_wr(4'h0, 32'h0000_0003);
    bus_rd(4'h4, rv);
    check_eq("blink_rd", rv, 32'h1);
    trans = 0; last_edge = -1; b1_bad = 0;
    prev = ledout[0];
    for (int i = 0; i < 25; i++) begin
      @(negedge led_clk);
      if (ledout[1] !== 1'b1) b1_bad++;
      if (ledout[LED_W-1:2] !== '0) b1_bad++;
      if (ledout[0] !== prev) begin
        if (last_edge >= 0) check_eq("blink_gap", 32'(i - last_edge), 32'd4);
        last_edge = i;
        trans++;
      end
      prev = ledout[0];
    end
    check_eq("blink_trans", 32'(trans >= 5), 32'h1);
    check_eq("blink_b1_steady", 32'(b1_bad), 32'h0);
    bus_wr(4'h1, 32'h0000_0000);
    bus_rd(4'h0, rv);
    check_eq("misalign_wr", rv, 32'h3);
    bus_rd(4'h1, rv);
    check_eq("misalign_rd", rv, 32'h0);

    // 5: PWM duty
    bus_wr(4'h4, 32'h0);
    bus_wr(4'h8, 32'h0000_0040);
    bus_rd(4'h8, rv);
    check_eq("duty_rd", rv, 32'h40);
    cnt = 0;
    for (int i = 0; i < 256; i++) begin
      @(negedge led_clk);
      if (ledout != '0) cnt++;
    end
    check_eq("duty40_on", 32'(cnt), 32'd64);
    bus_wr(4'h8, 32'h0);
    @(negedge led_clk);
    cnt = 0;
    for (int i = 0; i < 256; i++) begin
      @(negedge led_clk);
      if (ledout != '0) cnt++;
    end
    check_eq("duty0_on", 32'(cnt), 32'd0);
    bus_wr(4'h8, 32'h0000_01FF);
    bus_rd(4'h8, rv);
    check_eq("duty_trunc", rv, 32'hFF);
    cnt = 0;
    for (int i = 0; i < 256; i++) begin
      @(negedge led_clk);
      if (ledout == LED_W'(3)) cnt++;
    end
    check_eq("dutyff_on", 32'(cnt), 32'd256);

    // 6: same-cycle read and write
    bus_wr(4'h0, 32'h1);
    @(negedge led_clk);
    ledcs = 1'b1; ledwrite = 1'b1; ledread = 1'b1; ledaddr = 4'h0; ledwdata = 32'h2;
    @(negedge led_clk);
    ledcs = 1'b0; ledwrite = 1'b0; ledread = 1'b0;
    check_eq("rw_old", ledrdata, 32'h1);
    repeat (3) @(negedge led_clk);
    check_eq("rd_hold", ledrdata, 32'h1);
    bus_rd(4'h0, rv);
    check_eq("rw_new", rv, 32'h2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  function automatic logic [3:0] LED_REG_DUTY_ADDR();
    return 4'h8;
  endfunction

endmodule
